// File: rtl/phase_sequencer_pkg.sv
// Shared types and constants for the phase sequencer.
// State encoding, STP opcode and phase strobe decode.
package phase_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [3:0] OP_STP = 4'b0111;
  localparam int LOOP_MAX_DEF = 255;

  typedef struct packed {
    logic fetch;
    logic exec1;
    logic exec2;
    logic halted;
    logic fault;
  } phase_t;

  function automatic phase_t phase_dec(state_t s);
    phase_t p;
    p.fetch  = (s == S_FETCH);
    p.exec1  = (s == S_EXEC1);
    p.exec2  = (s == S_EXEC2);
    p.halted = (s == S_HALT);
    p.fault  = (s == S_FAULT);
    return p;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/strobe bundle between instruction decoder and sequencer.
// master drives requests, slave (the sequencer) drives phases.
interface phase_sequencer_if;
  logic        start;
  logic        step_mode;
  logic        step;
  logic [3:0]  op;
  logic        Extra;
  logic        Loop;
  logic        fetch;
  logic        exec1;
  logic        exec2;
  logic        count_en;
  logic        halted;
  logic        fault;
  logic [15:0] instr_count;
  logic [7:0]  loop_count;

  modport master (
    output start, step_mode, step, op, Extra, Loop,
    input  fetch, exec1, exec2, count_en, halted, fault,
    input  instr_count, loop_count
  );

  modport slave (
    input  start, step_mode, step, op, Extra, Loop,
    output fetch, exec1, exec2, count_en, halted, fault,
    output instr_count, loop_count
  );
endinterface

// File: rtl/phase_sequencer_loop_timer.sv
// Repeat-EXEC1 counter with timeout compare.
// Cleared on first EXEC1 entry, bumped on each repeat.
module loop_timer #(
  parameter int MAX = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] count,
  output logic       at_max,
  output logic       nonzero
);

  localparam logic [7:0] MAX8 = 8'(MAX);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign count   = r_count;
  assign at_max  = (r_count == MAX8);
  assign nonzero = (r_count != 8'd0);

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: FETCH/EXEC1/EXEC2 with halt,
// single-step and loop-timeout fault; counts retired instructions.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int LOOP_MAX = LOOP_MAX_DEF
) (
  input logic               clk,
  input logic               rst_n,
  phase_sequencer_if.slave  bus
);

  state_t      r_state;
  state_t      w_next;
  phase_t      r_ph;
  logic [15:0] r_icnt;
  logic        w_clear;
  logic        w_inc;
  logic        w_retire;
  logic        w_at_max;
  logic        w_nonzero;
  logic [7:0]  w_count;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_FETCH;
      S_FETCH: if (!bus.step_mode || bus.step) w_next = S_EXEC1;
      S_EXEC1: begin
        if (bus.op == OP_STP)  w_next = S_HALT;
        else if (bus.Loop)     w_next = w_at_max ? S_FAULT : S_EXEC1;
        else if (bus.Extra)    w_next = S_EXEC2;
        else                   w_next = S_FETCH;
      end
      S_EXEC2: w_next = S_FETCH;
      S_HALT:  if (bus.start) w_next = S_FETCH;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_clear  = (r_state == S_FETCH) && (w_next == S_EXEC1);
  assign w_inc    = (r_state == S_EXEC1) && (w_next == S_EXEC1);
  // An instruction retires when it leaves its last execute phase cleanly.
  assign w_retire = (r_state == S_EXEC2) ||
                    ((r_state == S_EXEC1) &&
                     ((w_next == S_FETCH) || (w_next == S_HALT)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ph    <= '0;
      r_icnt  <= '0;
    end else begin
      r_state <= w_next;
      r_ph    <= phase_dec(w_next);
      if (w_retire) r_icnt <= r_icnt + 16'd1;
    end
  end

  loop_timer #(
    .MAX (LOOP_MAX)
  ) u_loop (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_clear),
    .inc     (w_inc),
    .count   (w_count),
    .at_max  (w_at_max),
    .nonzero (w_nonzero)
  );

  assign bus.fetch       = r_ph.fetch;
  assign bus.exec1       = r_ph.exec1;
  assign bus.exec2       = r_ph.exec2;
  assign bus.halted      = r_ph.halted;
  assign bus.fault       = r_ph.fault;
  assign bus.count_en    = r_ph.exec1 & w_nonzero;
  assign bus.instr_count = r_icnt;
  assign bus.loop_count  = w_count;

endmodule
